ohm_sched: RTL

OHM_SCHED -- requirements
Module: ohm_sched

---
 rtl/ohm_pkg.sv | 20 ++
 rtl/rr_arb.sv | 39 +++
 rtl/ohm_sched.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ohm_pkg.sv
// Shared types and default constants for the igniter resistance measurement scheduler.
package ohm_pkg;
   localparam int unsigned WORD_W      = 12;
   localparam int unsigned DEF_NCH     = 4;
   localparam int unsigned DEF_DIV_LAT = 16;
   localparam int unsigned DEF_TMO     = 24;

   typedef logic [WORD_W-1:0] adc_word_t;
   typedef logic [WORD_W-1:0] ohm_word_t;

   localparam ohm_word_t DEF_OPEN_LIM  = 12'd2000;
   localparam ohm_word_t DEF_SHORT_LIM = 12'd5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_STORE = 2'd3
   } state_t;
endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: one-hot grant searched from the channel after the last winner.
module rr_arb #(
   parameter int unsigned NCH   = 4,
   parameter int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [NCH-1:0]   req,
   output logic [NCH-1:0]   grant,
   output logic [IDX_W-1:0] grant_idx
);
   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W-1:0] w_c;
   logic             w_found;

   // First requester found walking forward from r_ptr+1 wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      w_c       = '0;
      w_found   = 1'b0;
      for (int unsigned k = 1; k <= NCH; k++) begin
         w_c = IDX_W'((32'(r_ptr) + k) % NCH);
         if (!w_found && req[w_c]) begin
            grant[w_c] = 1'b1;
            grant_idx  = w_c;
            w_found    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr <= IDX_W'(NCH - 1);
      end else if (w_found) begin
         r_ptr <= grant_idx;
      end
   end
endmodule

// File: rtl/ohm_sched.sv
// Shares one fixed-latency divider among NCH igniter channels; optional continuity
// classification of each result is built when OHM_SCHED_CONT_EN is defined.
module ohm_sched
   import ohm_pkg::*;
#(
   parameter int unsigned NCH       = DEF_NCH,
   parameter int unsigned DIV_LAT   = DEF_DIV_LAT,
   parameter int unsigned TMO       = DEF_TMO,
   parameter ohm_word_t   OPEN_LIM  = DEF_OPEN_LIM,
   parameter ohm_word_t   SHORT_LIM = DEF_SHORT_LIM
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NCH-1:0]        req_valid,
   input  logic [NCH*WORD_W-1:0] req_v,
   input  logic [NCH*WORD_W-1:0] req_i,
   output logic [NCH-1:0]        req_ready,
   output logic                  div_valid_in,
   output logic [WORD_W-1:0]     div_v_in,
   output logic [WORD_W-1:0]     div_i_in,
   input  logic                  div_valid_out,
   input  logic [WORD_W-1:0]     div_r_out,
   output logic [NCH-1:0]        res_valid,
   output logic [NCH*WORD_W-1:0] res_ohm,
   output logic [NCH-1:0]        cont_ok,
   output logic [NCH-1:0]        cont_open,
   output logic [NCH-1:0]        cont_short,
   output logic                  err_tmo
);
   localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned CNT_W = $clog2(TMO + 1);

   if ((TMO <= DIV_LAT) || (SHORT_LIM > OPEN_LIM)) begin : g_bad_cfg
      $error("ohm_sched: requires TMO > DIV_LAT and SHORT_LIM <= OPEN_LIM");
   end

   state_t           r_state, w_state_nxt;
   logic             r_div_valid_in, w_div_valid_nxt;
   adc_word_t        r_div_v_in, w_div_v_nxt;
   adc_word_t        r_div_i_in, w_div_i_nxt;
   logic [IDX_W-1:0] r_tag, w_tag_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   ohm_word_t        r_r, w_r_nxt;
   logic [NCH-1:0]   r_res_valid, w_res_valid_nxt;
   ohm_word_t        r_res_ohm [NCH];
   ohm_word_t        w_res_ohm_nxt [NCH];
   logic             r_err_tmo, w_err_nxt;

   adc_word_t        w_req_v [NCH];
   adc_word_t        w_req_i [NCH];
   logic [NCH-1:0]   w_arb_req;
   logic [NCH-1:0]   w_grant;
   logic [IDX_W-1:0] w_gidx;

   for (genvar c = 0; c < NCH; c++) begin : g_lane
      assign w_req_v[c]                    = req_v[c*WORD_W +: WORD_W];
      assign w_req_i[c]                    = req_i[c*WORD_W +: WORD_W];
      assign res_ohm[c*WORD_W +: WORD_W]   = r_res_ohm[c];
   end

   // Arbitration is only live in IDLE, so the pointer advances exactly once per grant.
   assign w_arb_req = (r_state == ST_IDLE) ? req_valid : '0;

   rr_arb #(
      .NCH   (NCH),
      .IDX_W (IDX_W)
   ) u_rr_arb (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (w_arb_req),
      .grant     (w_grant),
      .grant_idx (w_gidx)
   );

   assign req_ready    = reset_n ? w_grant : '0;
   assign div_valid_in = r_div_valid_in;
   assign div_v_in     = r_div_v_in;
   assign div_i_in     = r_div_i_in;
   assign res_valid    = r_res_valid;
   assign err_tmo      = r_err_tmo;

`ifdef OHM_SCHED_CONT_EN
   logic [NCH-1:0] r_cont_ok, r_cont_open, r_cont_short;
   logic [NCH-1:0] w_ok_nxt, w_open_nxt, w_short_nxt;
   assign cont_ok    = r_cont_ok;
   assign cont_open  = r_cont_open;
   assign cont_short = r_cont_short;
`else
   assign cont_ok    = '0;
   assign cont_open  = '0;
   assign cont_short = '0;
`endif

   always_comb begin
      w_state_nxt     = r_state;
      w_div_valid_nxt = 1'b0;
      w_div_v_nxt     = r_div_v_in;
      w_div_i_nxt     = r_div_i_in;
      w_tag_nxt       = r_tag;
      w_cnt_nxt       = r_cnt;
      w_r_nxt         = r_r;
      w_res_valid_nxt = '0;
      w_res_ohm_nxt   = r_res_ohm;
      w_err_nxt       = r_err_tmo;
`ifdef OHM_SCHED_CONT_EN
      w_ok_nxt        = r_cont_ok;
      w_open_nxt      = r_cont_open;
      w_short_nxt     = r_cont_short;
`endif
      case (r_state)
         ST_IDLE: begin
            // Launch strobe is registered so it is high exactly during ISSUE.
            if (|w_grant) begin
               w_div_valid_nxt = 1'b1;
               w_div_v_nxt     = w_req_v[w_gidx];
               w_div_i_nxt     = w_req_i[w_gidx];
               w_tag_nxt       = w_gidx;
               w_state_nxt     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (div_valid_out) begin
               w_r_nxt     = div_r_out;
               w_state_nxt = ST_STORE;
            end else if (r_cnt == CNT_W'(TMO - 1)) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
         end
         ST_STORE: begin
            w_res_ohm_nxt[r_tag]   = r_r;
            w_res_valid_nxt[r_tag] = 1'b1;
`ifdef OHM_SCHED_CONT_EN
            w_open_nxt[r_tag]      = (r_r > OPEN_LIM);
            w_short_nxt[r_tag]     = (r_r <= OPEN_LIM) && (r_r < SHORT_LIM);
            w_ok_nxt[r_tag]        = (r_r <= OPEN_LIM) && (r_r >= SHORT_LIM);
`endif
            w_state_nxt            = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= ST_IDLE;
         r_div_valid_in <= 1'b0;
         r_div_v_in     <= '0;
         r_div_i_in     <= '0;
         r_tag          <= '0;
         r_cnt          <= '0;
         r_r            <= '0;
         r_res_valid    <= '0;
         r_res_ohm      <= '{default: '0};
         r_err_tmo      <= 1'b0;
`ifdef OHM_SCHED_CONT_EN
         r_cont_ok      <= '0;
         r_cont_open    <= '0;
         r_cont_short   <= '0;
`endif
      end else begin
         r_state        <= w_state_nxt;
         r_div_valid_in <= w_div_valid_nxt;
         r_div_v_in     <= w_div_v_nxt;
         r_div_i_in     <= w_div_i_nxt;
         r_tag          <= w_tag_nxt;
         r_cnt          <= w_cnt_nxt;
         r_r            <= w_r_nxt;
         r_res_valid    <= w_res_valid_nxt;
         r_res_ohm      <= w_res_ohm_nxt;
         r_err_tmo      <= w_err_nxt;
`ifdef OHM_SCHED_CONT_EN
         r_cont_ok      <= w_ok_nxt;
         r_cont_open    <= w_open_nxt;
         r_cont_short   <= w_short_nxt;
`endif
      end
   end
endmodule
